// File: rtl/chan_mem_arb.sv
// chan_mem_arb: shares the 128x32 channel-state RAM between the channel sequencer
// (absolute priority) and the byte-wide host port. Host read path: CHAN_ARB_READBACK_EN.
module chan_mem_arb #(
    parameter int unsigned RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ctrl_busy,
    input  logic [6:0]  ctrl_rd_addr,
    output logic [31:0] ctrl_rd_data,
    input  logic [6:0]  ctrl_wr_addr,
    input  logic [31:0] ctrl_wr_data,
    input  logic        ctrl_wr_stb,
    output logic [6:0]  mem_rd_addr,
    input  logic [31:0] mem_rd_data,
    output logic [6:0]  mem_wr_addr,
    output logic [31:0] mem_wr_data,
    output logic        mem_wr_en,
    input  logic [6:0]  host_addr,
    input  logic [1:0]  host_byte,
    input  logic [7:0]  host_wdata,
    input  logic        host_wr_stb,
    input  logic        host_rd_stb,
    output logic [7:0]  host_rdata,
    output logic        host_rd_vld,
    output logic        host_busy,
    output logic        host_err
);
    localparam int unsigned AW = 7;
    localparam int unsigned DW = 32;

    if (RD_LAT != 1) begin : g_rd_lat_unsupported
        $error("chan_mem_arb supports RD_LAT == 1 only");
    end

`ifdef CHAN_ARB_READBACK_EN
    typedef enum logic [2:0] {H_IDLE, H_WPEND, H_RWAIT, H_RISSUE, H_RDATA} h_state_e;
`else
    typedef enum logic [0:0] {H_IDLE, H_WPEND} h_state_e;
`endif

    h_state_e      state_q, state_d;
    logic [DW-1:0] shadow_q;
    logic [AW-1:0] host_addr_q;
    logic          drop_q;
    logic [AW-1:0] drop_addr_q;
    logic          ctrl_busy_q;

    logic host_idle;
    logic wr_acc;
    logic rd_acc;
    logic strobe_err;
    logic host_commit;
    logic drop_hit;
    logic hazard;

    assign host_idle   = (state_q == H_IDLE);
    assign wr_acc      = host_idle && host_wr_stb;
    assign host_commit = (state_q == H_WPEND) && !ctrl_wr_stb;
    assign drop_hit    = ctrl_wr_stb && drop_q && (ctrl_wr_addr == drop_addr_q);
    // Host overwrote the running offset of the channel the sequencer is walking.
    assign hazard      = host_commit && ctrl_busy && (host_addr_q[1:0] == 2'b00) &&
                         (host_addr_q[6:2] == ctrl_rd_addr[6:2]);
    assign ctrl_rd_data = mem_rd_data;

`ifdef CHAN_ARB_READBACK_EN
    logic [1:0] host_byte_q;

    assign rd_acc      = host_idle && host_rd_stb && !host_wr_stb;
    assign strobe_err  = (!host_idle && (host_wr_stb || host_rd_stb)) ||
                         (host_idle && host_wr_stb && host_rd_stb);
    assign mem_rd_addr = ((state_q == H_RISSUE) && !ctrl_busy) ? host_addr_q : ctrl_rd_addr;

    // Read-back byte capture, one clock after the RAM address was issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            host_byte_q <= 2'b00;
            host_rdata  <= 8'h00;
            host_rd_vld <= 1'b0;
        end else begin
            if (rd_acc) begin
                host_byte_q <= host_byte;
            end
            host_rd_vld <= (state_q == H_RDATA);
            if (state_q == H_RDATA) begin
                host_rdata <= mem_rd_data[{host_byte_q, 3'b000} +: 8];
            end
        end
    end
`else
    logic unused_rd_stb;

    assign unused_rd_stb = host_rd_stb;
    assign rd_acc        = 1'b0;
    assign strobe_err    = !host_idle && host_wr_stb;
    assign mem_rd_addr   = ctrl_rd_addr;
    assign host_rdata    = 8'h00;
    assign host_rd_vld   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= H_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            H_IDLE: begin
                if (host_wr_stb) begin
                    if (host_byte == 2'd3) begin
                        state_d = H_WPEND;
                    end
`ifdef CHAN_ARB_READBACK_EN
                end else if (host_rd_stb) begin
                    state_d = H_RWAIT;
`endif
                end
            end
            H_WPEND: begin
                if (!ctrl_wr_stb) begin
                    state_d = H_IDLE;
                end
            end
`ifdef CHAN_ARB_READBACK_EN
            H_RWAIT: begin
                if (!ctrl_busy) begin
                    state_d = H_RISSUE;
                end
            end
            H_RISSUE: begin
                state_d = ctrl_busy ? H_RWAIT : H_RDATA;
            end
            H_RDATA: begin
                state_d = H_IDLE;
            end
`endif
            default: state_d = H_IDLE;
        endcase
    end

    // Shadow word, write port, drop flag and host status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q    <= '0;
            host_addr_q <= '0;
            drop_q      <= 1'b0;
            drop_addr_q <= '0;
            ctrl_busy_q <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
            host_busy   <= 1'b0;
            host_err    <= 1'b0;
        end else begin
            if (wr_acc) begin
                shadow_q[{host_byte, 3'b000} +: 8] <= host_wdata;
            end
            if ((wr_acc && (host_byte == 2'd3)) || rd_acc) begin
                host_addr_q <= host_addr;
            end

            mem_wr_en <= 1'b0;
            if (ctrl_wr_stb) begin
                if (!drop_hit) begin
                    mem_wr_en   <= 1'b1;
                    mem_wr_addr <= ctrl_wr_addr;
                    mem_wr_data <= ctrl_wr_data;
                end
            end else if (state_q == H_WPEND) begin
                mem_wr_en   <= 1'b1;
                mem_wr_addr <= host_addr_q;
                mem_wr_data <= shadow_q;
            end

            if (hazard) begin
                drop_q      <= 1'b1;
                drop_addr_q <= {host_addr_q[6:2], 2'b00};
            end else if (drop_hit || (ctrl_busy_q && !ctrl_busy)) begin
                drop_q <= 1'b0;
            end
            ctrl_busy_q <= ctrl_busy;

            host_busy <= (state_d != H_IDLE);
            if (strobe_err) begin
                host_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_chan_mem_arb.sv
// tb_chan_mem_arb: directed bench for chan_mem_arb with a RAM model and
// write/read scoreboards; covers both builds of CHAN_ARB_READBACK_EN.
module tb_chan_mem_arb;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ctrl_busy = 1'b0;
    logic [6:0]  ctrl_rd_addr = '0;
    logic [31:0] ctrl_rd_data;
    logic [6:0]  ctrl_wr_addr = '0;
    logic [31:0] ctrl_wr_data = '0;
    logic        ctrl_wr_stb = 1'b0;
    logic [6:0]  mem_rd_addr;
    logic [31:0] mem_rd_data;
    logic [6:0]  mem_wr_addr;
    logic [31:0] mem_wr_data;
    logic        mem_wr_en;
    logic [6:0]  host_addr = '0;
    logic [1:0]  host_byte = '0;
    logic [7:0]  host_wdata = '0;
    logic        host_wr_stb = 1'b0;
    logic        host_rd_stb = 1'b0;
    logic [7:0]  host_rdata;
    logic        host_rd_vld;
    logic        host_busy;
    logic        host_err;

    typedef struct packed {
        logic [6:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t         wr_q[$];
    logic [7:0]  rd_q[$];
    wr_t         w;
    logic [7:0]  rb;
    logic [31:0] ram [128];
    logic [31:0] exp_0c;
    int          n_err = 0;
    int          n_chk = 0;

    chan_mem_arb #(.RD_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .ctrl_busy(ctrl_busy), .ctrl_rd_addr(ctrl_rd_addr), .ctrl_rd_data(ctrl_rd_data),
        .ctrl_wr_addr(ctrl_wr_addr), .ctrl_wr_data(ctrl_wr_data), .ctrl_wr_stb(ctrl_wr_stb),
        .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .mem_wr_en(mem_wr_en),
        .host_addr(host_addr), .host_byte(host_byte), .host_wdata(host_wdata),
        .host_wr_stb(host_wr_stb), .host_rd_stb(host_rd_stb),
        .host_rdata(host_rdata), .host_rd_vld(host_rd_vld),
        .host_busy(host_busy), .host_err(host_err)
    );

    always #5 clk = ~clk;

    // RAM model: synchronous write, 1-clock registered read.
    always @(posedge clk) begin
        if (mem_wr_en) ram[mem_wr_addr] <= mem_wr_data;
        mem_rd_data <= ram[mem_rd_addr];
    end

    // Scoreboard monitors on the falling edge.
    always @(negedge clk) begin
        if (rst_n && mem_wr_en) begin
            n_chk++;
            if (wr_q.size() == 0) begin
                n_err++;
                $error("FAIL wr_unexpected addr=%h data=%h", mem_wr_addr, mem_wr_data);
            end else begin
                w = wr_q.pop_front();
                assert ({mem_wr_addr, mem_wr_data} === {w.a, w.d}) else begin
                    n_err++;
                    $error("FAIL wr_sb obs=%h/%h exp=%h/%h", mem_wr_addr, mem_wr_data, w.a, w.d);
                end
            end
        end
        if (rst_n && host_rd_vld) begin
            n_chk++;
            if (rd_q.size() == 0) begin
                n_err++;
                $error("FAIL rd_unexpected data=%h", host_rdata);
            end else begin
                rb = rd_q.pop_front();
                assert (host_rdata === rb) else begin
                    n_err++;
                    $error("FAIL rd_sb obs=%h exp=%h", host_rdata, rb);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic host_wr(input logic [6:0] a, input logic [1:0] b, input logic [7:0] d);
        host_addr   = a;
        host_byte   = b;
        host_wdata  = d;
        host_wr_stb = 1'b1;
        tick();
        host_wr_stb = 1'b0;
    endtask

    task automatic ctrl_wr(input logic [6:0] a, input logic [31:0] d);
        ctrl_wr_addr = a;
        ctrl_wr_data = d;
        ctrl_wr_stb  = 1'b1;
        tick();
        ctrl_wr_stb  = 1'b0;
    endtask

    task automatic host_rd(input logic [6:0] a, input logic [1:0] b);
        host_addr   = a;
        host_byte   = b;
        host_rd_stb = 1'b1;
        tick();
        host_rd_stb = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) ram[i] = 32'h0;
        repeat (2) tick();
        chk("rst_busy", host_busy, 0);
        chk("rst_vld", host_rd_vld, 0);
        chk("rst_err", host_err, 0);
        chk("rst_wen", mem_wr_en, 0);
        chk("rst_rdata", host_rdata, 0);
        rst_n = 1'b1;
        tick();

        // Full word assembled from four lanes, committed once.
        host_wr(7'h05, 2'd0, 8'h11);
        host_wr(7'h05, 2'd1, 8'h22);
        host_wr(7'h05, 2'd2, 8'h33);
        chk("w_partial_noen", mem_wr_en, 0);
        wr_q.push_back('{a: 7'h05, d: 32'h44332211});
        host_wr(7'h05, 2'd3, 8'h44);
        chk("w_busy", host_busy, 1);
        chk("w_en_early", mem_wr_en, 0);
        tick();
        chk("w_en", mem_wr_en, 1);
        chk("w_busy_done", host_busy, 0);
        tick();
        chk("w_single_pulse", mem_wr_en, 0);

        // Ctrl strobe in the host commit cycle: ctrl first, host one clock later.
        host_wr(7'h13, 2'd3, 8'hA5);
        wr_q.push_back('{a: 7'h10, d: 32'hDEADBEEF});
        wr_q.push_back('{a: 7'h13, d: 32'hA5332211});
        chk("coll_busy0", host_busy, 1);
        ctrl_wr(7'h10, 32'hDEADBEEF);
        chk("coll_ctrl_addr", mem_wr_addr, 7'h10);
        chk("coll_busy1", host_busy, 1);
        tick();
        chk("coll_host_en", mem_wr_en, 1);
        chk("coll_host_addr", mem_wr_addr, 7'h13);
        chk("coll_busy2", host_busy, 0);
        tick();

        // Offset hazard: host value survives the sequencer's next writeback.
        ctrl_busy    = 1'b1;
        ctrl_rd_addr = 7'h0C;
        host_wr(7'h0C, 2'd0, 8'h00);
        host_wr(7'h0C, 2'd1, 8'h10);
        host_wr(7'h0C, 2'd2, 8'h00);
        wr_q.push_back('{a: 7'h0C, d: 32'h00001000});
        host_wr(7'h0C, 2'd3, 8'h00);
        tick();
        tick();
        ctrl_wr(7'h0C, 32'hCAFEF00D);
        chk("drop_noen", mem_wr_en, 0);
        tick();
        chk("drop_ram", ram[7'h0C], 32'h00001000);
        wr_q.push_back('{a: 7'h0C, d: 32'h12345678});
        ctrl_wr(7'h0C, 32'h12345678);
        chk("drop_cleared_en", mem_wr_en, 1);
        tick();
        chk("drop_cleared_ram", ram[7'h0C], 32'h12345678);

        // Drop flag also cleared by ctrl_busy falling.
        wr_q.push_back('{a: 7'h0C, d: 32'h00001000});
        host_wr(7'h0C, 2'd3, 8'h00);
        tick();
        ctrl_busy = 1'b0;
        tick();
        ctrl_busy = 1'b1;
        tick();
        exp_0c = 32'h0BADC0DE;
        wr_q.push_back('{a: 7'h0C, d: exp_0c});
        ctrl_wr(7'h0C, exp_0c);
        chk("drop_fall_en", mem_wr_en, 1);
        tick();
        ctrl_busy = 1'b0;

`ifdef CHAN_ARB_READBACK_EN
        wr_q.push_back('{a: 7'h07, d: 32'hAABBCCDD});
        ctrl_wr(7'h07, 32'hAABBCCDD);
        tick();
        rd_q.push_back(8'hBB);
        host_rd(7'h07, 2'd2);
        chk("rd_busy", host_busy, 1);
        tick();
        chk("rd_vld_e1", host_rd_vld, 0);
        tick();
        chk("rd_vld_e2", host_rd_vld, 0);
        tick();
        chk("rd_vld", host_rd_vld, 1);
        chk("rd_data", host_rdata, 8'hBB);
        chk("rd_busy_done", host_busy, 0);
        tick();
        chk("rd_vld_pulse", host_rd_vld, 0);

        // Read held off while the sequencer walks channels.
        ctrl_busy = 1'b1;
        rd_q.push_back(8'hDD);
        host_rd(7'h07, 2'd0);
        for (int i = 0; i < 200; i++) begin
            tick();
            chk("hold_busy", host_busy, 1);
            chk("hold_vld", host_rd_vld, 0);
            chk("hold_rd_addr", mem_rd_addr, 7'h0C);
            chk("hold_ctrl_data", ctrl_rd_data, exp_0c);
        end
        ctrl_busy = 1'b0;
        tick();
        chk("hold_vld_f1", host_rd_vld, 0);
        tick();
        chk("hold_vld_f2", host_rd_vld, 0);
        tick();
        chk("hold_vld_f3", host_rd_vld, 1);
        chk("hold_data", host_rdata, 8'hDD);

        // Issue voided when ctrl_busy rises during the issue cycle.
        tick();
        rd_q.push_back(8'hAA);
        host_rd(7'h07, 2'd3);
        tick();
        ctrl_busy = 1'b1;
        #1;
        chk("void_rd_addr", mem_rd_addr, 7'h0C);
        tick();
        ctrl_busy = 1'b0;
        tick();
        chk("reissue_rd_addr", mem_rd_addr, 7'h07);
        tick();
        chk("reissue_vld_early", host_rd_vld, 0);
        tick();
        chk("reissue_vld", host_rd_vld, 1);
        chk("reissue_data", host_rdata, 8'hAA);
        tick();

        // Simultaneous strobes: write wins, error flagged.
        host_addr   = 7'h20;
        host_byte   = 2'd0;
        host_wdata  = 8'h99;
        host_wr_stb = 1'b1;
        host_rd_stb = 1'b1;
        tick();
        host_wr_stb = 1'b0;
        host_rd_stb = 1'b0;
        chk("both_err", host_err, 1);
        chk("both_busy", host_busy, 0);
`else
        host_rd(7'h07, 2'd2);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("nord_vld", host_rd_vld, 0);
        end
        chk("nord_busy", host_busy, 0);
        chk("nord_err", host_err, 0);
        chk("nord_rdata", host_rdata, 0);
        chk("nord_rd_addr", mem_rd_addr, 7'h0C);

        host_addr   = 7'h20;
        host_byte   = 2'd0;
        host_wdata  = 8'h99;
        host_wr_stb = 1'b1;
        host_rd_stb = 1'b1;
        tick();
        host_wr_stb = 1'b0;
        host_rd_stb = 1'b0;
        chk("both_noerr", host_err, 0);
        chk("both_busy", host_busy, 0);
`endif

        // Strobe while busy is ignored and sets the sticky error.
        wr_q.push_back('{a: 7'h20, d: 32'h77001099});
        host_wr(7'h20, 2'd3, 8'h77);
        host_wr(7'h20, 2'd0, 8'hEE);
        chk("busy_err", host_err, 1);
        repeat (3) tick();
        chk("busy_err_sticky", host_err, 1);

        // Reset during a pending commit abandons it.
        host_wr(7'h21, 2'd3, 8'h01);
        rst_n = 1'b0;
        #1;
        chk("midrst_wen", mem_wr_en, 0);
        chk("midrst_err", host_err, 0);
        chk("midrst_busy", host_busy, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("postrst_wen", mem_wr_en, 0);
        chk("postrst_ram", ram[7'h21], 32'h0);

        // Shadow cleared by reset.
        wr_q.push_back('{a: 7'h22, d: 32'h5A000000});
        host_wr(7'h22, 2'd3, 8'h5A);
        repeat (3) tick();

        chk("wr_q_empty", wr_q.size(), 0);
        chk("rd_q_empty", rd_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/chan_mem_arb.md
Name: chan_mem_arb

Overview:
- Arbiter for the 128x32 channel-state RAM, which holds 32 channels x 4 words.
- Shares the RAM between the DMA channel sequencer (ctrl side) and the Z80 host register interface (byte-wide).
- Ctrl side has absolute priority. Host writes are assembled into 32-bit words in a shadow latch and committed into free write-port cycles. Host reads are served only while the sequencer is idle.
- Sits between the channel sequencer, the state RAM and the host port decoder.

Parameters:
- RD_LAT, 1, state-RAM synchronous read latency in clocks; only 1 is supported.

Ports:
- clk  in  1  system clock, 24.0 MHz
- rst_n  in  1  asynchronous reset, active-low
- ctrl_busy  in  1  sequencer is walking channels (not in its wait state); ctrl owns the read port while high
- ctrl_rd_addr  in  7  sequencer read address {ch[4:0],word[1:0]}
- ctrl_rd_data  out  32  read data to sequencer (= mem_rd_data)
- ctrl_wr_addr  in  7  sequencer write address
- ctrl_wr_data  in  32  sequencer write data
- ctrl_wr_stb  in  1  sequencer write strobe, 1 cycle
- mem_rd_addr  out  7  RAM read address
- mem_rd_data  in  32  RAM read data, valid 1 clk after address
- mem_wr_addr  out  7  RAM write address
- mem_wr_data  out  32  RAM write data
- mem_wr_en  out  1  RAM write enable
- host_addr  in  7  host word address
- host_byte  in  2  byte lane (0 = bits 7:0 ... 3 = bits 31:24)
- host_wdata  in  8  host write byte
- host_wr_stb  in  1  host byte-write strobe, 1 cycle
- host_rd_stb  in  1  host byte-read strobe, 1 cycle
- host_rdata  out  8  read-back byte
- host_rd_vld  out  1  host_rdata valid, 1-cycle strobe
- host_busy  out  1  host request pending; new strobes ignored
- host_err  out  1  sticky: a strobe arrived while host_busy; cleared only by reset

Behaviour:
- Reset values:
  - host_busy, host_rd_vld, host_err, mem_wr_en = 0
  - host_rdata = 0; shadow latch = 0
  - host FSM = H_IDLE; drop flag = 0
- Read mux (combinational):
  - mem_rd_addr = ctrl_rd_addr when ctrl_busy=1 or FSM is not in H_RISSUE; host_addr latch only in H_RISSUE.
  - ctrl_rd_data = mem_rd_data always.
- Write port, registered, 1 clk latency from the strobe:
  - If ctrl_wr_stb: write ctrl_addr/data, unless the drop flag is set and ctrl_wr_addr equals the drop address. In that case mem_wr_en stays 0 and the drop flag clears.
  - Else if FSM is in H_WPEND: write the shadow word to the latched host address; FSM goes to H_IDLE.
  - The host write is never lost; it retries every cycle ctrl_wr_stb is high.
- Host FSM states: H_IDLE, H_WPEND, H_RWAIT, H_RISSUE, H_RDATA.
- H_IDLE:
  - host_wr_stb: the shadow lane host_byte is loaded with host_wdata.
    - host_byte != 3: stay in H_IDLE, no RAM access.
    - host_byte == 3: latch host_addr, go to H_WPEND.
  - host_rd_stb: latch addr/byte, go to H_RWAIT.
  - Both strobes in the same cycle: the write wins, the read is ignored and host_err is set.
- H_RWAIT: when ctrl_busy=0 go to H_RISSUE; else stay.
- H_RISSUE:
  - ctrl_busy=1 in this cycle: return to H_RWAIT; the issue is void.
  - Else go to H_RDATA.
- H_RDATA:
  - Load host_rdata with the selected byte of mem_rd_data and pulse host_rd_vld.
  - Return to H_IDLE.
  - Latency from strobe, ctrl idle: host_rd_vld high 3 clks after host_rd_stb.
- host_busy = 1 in H_WPEND, H_RWAIT, H_RISSUE, H_RDATA.
  - Any host strobe while host_busy is ignored and sets host_err.
- Offset hazard (word 0 holds the sequencer's running offset):
  - Trigger: a host commit to word 0 is written to RAM while ctrl_busy=1 and host_addr[6:2]==ctrl_rd_addr[6:2].
  - Action: set the drop flag and store the drop address = {ch,2'b00}. The sequencer's next writeback to that address is suppressed, so the host value survives.
  - The drop flag also clears on the falling edge of ctrl_busy.
- Shadow latch is not cleared after a commit; partial re-writes reuse the old lanes.
- Reset mid-operation: a pending commit or read is abandoned; no RAM write occurs after rst_n falls.

Optional Feature:
- Macro CHAN_ARB_READBACK_EN.
- Defined: the full host read path exists (H_RWAIT/H_RISSUE/H_RDATA).
- Undefined:
  - The read states are absent and host_rd_stb is ignored; it does not set host_err.
  - host_rdata and host_rd_vld are tied to 0.
  - mem_rd_addr = ctrl_rd_addr permanently.

Test Plan:
- Host writes bytes 0x11,0x22,0x33,0x44 to addr 0x05 lanes 0..3, ctrl idle -> one mem_wr_en pulse, addr 0x05, data 0x44332211, 1 clk after the lane-3 strobe.
- Lane-3 host write in the same cycle as ctrl_wr_stb (addr 0x10, data 0xDEADBEEF) -> ctrl write 0x10/0xDEADBEEF first, host write on the next cycle, host_busy high for 2 clks.
- ctrl_busy=1, ctrl_rd_addr=0x0C (ch 3), host commits 0x00001000 to addr 0x0C, then ctrl_wr_stb to 0x0C -> ctrl write suppressed, RAM word 0x0C = 0x00001000; a later ctrl write to 0x0C is honoured.
- Host read addr 0x07 byte 2 with RAM=0xAABBCCDD, ctrl idle -> host_rd_vld 3 clks later, host_rdata=0xBB.
- Same read issued with ctrl_busy=1 for 200 clks -> host_busy held, ctrl reads unaffected; host_rd_vld 3 clks after ctrl_busy falls.
- Second host_wr_stb while host_busy -> ignored, host_err=1 until reset; readback macro undefined -> host_rd_stb never produces host_rd_vld.
